clk_meas: RTL and testbench



---
 rtl/clk_meas.sv | 179 +++++++++++++++++
 tb/tb_clk_meas.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_meas.sv
// clk_meas: measures period and high time of a slow asynchronous clock-like
// input in units of clk_ref cycles. Also produces per-edge strobes and flags
// an input that has stopped toggling. clk_in is only ever sampled as data.
module clk_meas #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic             clk_ref,
  input  logic             arst_n,
  input  logic             clk_in,
  input  logic             clr,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_stb,
  output logic             meas_valid,
  output logic             stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  // Synchroniser and edge detection
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s;
  logic                   rise;
  logic                   fall;
  logic                   rise_stb_q;
  logic                   fall_stb_q;

  // Measurement state
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       hi_cap_q, hi_cap_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   meas_stb_q, meas_stb_d;
  logic                   valid_q, valid_d;
  logic                   stall_q, stall_d;

  logic [CNT_W-1:0]       cnt_inc;
  logic                   timeout;

  // Bring clk_in into the clk_ref domain and keep one extra delayed copy.
  always_ff @(posedge clk_ref or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      s_d_q  <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  // Registered edge strobes; unaffected by clr since the synchroniser is not.
  always_ff @(posedge clk_ref or negedge arst_n) begin
    if (!arst_n) begin
      rise_stb_q <= 1'b0;
      fall_stb_q <= 1'b0;
    end else begin
      rise_stb_q <= rise;
      fall_stb_q <= fall;
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign timeout = (cnt_q == TIMEOUT_C);

  // Measurement state and result registers.
  always_ff @(posedge clk_ref or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hi_cap_q   <= '0;
      period_q   <= '0;
      high_q     <= '0;
      meas_stb_q <= 1'b0;
      valid_q    <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_cap_q   <= hi_cap_d;
      period_q   <= period_d;
      high_q     <= high_d;
      meas_stb_q <= meas_stb_d;
      valid_q    <= valid_d;
      stall_q    <= stall_d;
    end
  end

  // Next-state logic: clr beats any edge, an edge beats the timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_cap_d   = hi_cap_q;
    period_d   = period_q;
    high_d     = high_q;
    meas_stb_d = 1'b0;
    valid_d    = valid_q;
    stall_d    = stall_q;

    if (clr) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      hi_cap_d = '0;
      period_d = '0;
      high_d   = '0;
      valid_d  = 1'b0;
      stall_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // First rise only starts counting; the partial period is dropped.
          if (rise) begin
            cnt_d    = CNT_ONE;
            hi_cap_d = '0;
            state_d  = S_HIGH;
          end
        end
        S_HIGH: begin
          if (fall) begin
            hi_cap_d = cnt_q;
            cnt_d    = cnt_inc;
            state_d  = S_LOW;
          end else if (timeout) begin
            state_d = S_IDLE;
            stall_d = 1'b1;
            valid_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_LOW: begin
          if (rise) begin
            period_d   = cnt_q;
            high_d     = hi_cap_q;
            meas_stb_d = 1'b1;
            valid_d    = 1'b1;
            cnt_d      = CNT_ONE;
            state_d    = S_HIGH;
          end else if (timeout) begin
            state_d = S_IDLE;
            stall_d = 1'b1;
            valid_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign rise_stb   = rise_stb_q;
  assign fall_stb   = fall_stb_q;
  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_stb   = meas_stb_q;
  assign meas_valid = valid_q;
  assign stall      = stall_q;

endmodule

// File: tb/tb_clk_meas.sv
// Bench for clk_meas: two instances (2 and 3 synchroniser stages) driven by
// the same clk_in, checked every cycle against a timestamp-based model.
module tb_clk_meas;

  localparam int TO    = 64;
  localparam int MAXN  = 20000;

  logic        clk_ref = 1'b0;
  logic        arst_n;
  logic        clk_in;
  logic        clr;

  logic        r0, f0, ms0, mv0, st0;
  logic        r1, f1, ms1, mv1, st1;
  logic [15:0] p0, h0, p1, h1;

  always #5 clk_ref = ~clk_ref;

  clk_meas #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .clk_ref(clk_ref), .arst_n(arst_n), .clk_in(clk_in), .clr(clr),
    .rise_stb(r0), .fall_stb(f0), .period(p0), .high_time(h0),
    .meas_stb(ms0), .meas_valid(mv0), .stall(st0)
  );

  clk_meas #(.CNT_W(16), .SYNC_STAGES(3), .TIMEOUT(TO)) dut3 (
    .clk_ref(clk_ref), .arst_n(arst_n), .clk_in(clk_in), .clr(clr),
    .rise_stb(r1), .fall_stb(f1), .period(p1), .high_time(h1),
    .meas_stb(ms1), .meas_valid(mv1), .stall(st1)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n       = 0;   // index of the next clk_ref posedge after reset release
  int base    = 0;   // first edge index whose sample is not flushed by reset

  bit samp [0:MAXN-1];

  // Model: per instance, mode 0 idle / 1 high phase / 2 low phase, plus
  // timestamps (edge indices) of the last registered rise and fall.
  int          m_mode  [2];
  int          m_trise [2];
  int          m_tfall [2];
  logic [15:0] e_period[2];
  logic [15:0] e_high  [2];
  bit          e_rise  [2];
  bit          e_fall  [2];
  bit          e_mstb  [2];
  bit          e_valid [2];
  bit          e_stall [2];

  function automatic bit smp(input int i);
    if (i < base) return 1'b0;
    return samp[i];
  endfunction

  task automatic model_reset();
    base = n;
    for (int u = 0; u < 2; u++) begin
      m_mode[u] = 0; m_trise[u] = 0; m_tfall[u] = 0;
      e_period[u] = '0; e_high[u] = '0;
      e_rise[u] = 0; e_fall[u] = 0; e_mstb[u] = 0; e_valid[u] = 0; e_stall[u] = 0;
    end
  endtask

  // A level first sampled at edge k is seen as an edge at edge k+S.
  task automatic model_edge(input bit c);
    for (int u = 0; u < 2; u++) begin
      int S;
      bit rz, fl, tmo;
      S   = u + 2;
      rz  = smp(n - S) & ~smp(n - S - 1);
      fl  = ~smp(n - S) & smp(n - S - 1);
      tmo = (n - m_trise[u]) == TO;
      e_rise[u] = rz;
      e_fall[u] = fl;
      e_mstb[u] = 0;
      if (c) begin
        m_mode[u] = 0; e_period[u] = '0; e_high[u] = '0;
        e_valid[u] = 0; e_stall[u] = 0;
      end else if (m_mode[u] == 0) begin
        if (rz) begin m_mode[u] = 1; m_trise[u] = n; end
      end else if (m_mode[u] == 1 && fl) begin
        m_tfall[u] = n; m_mode[u] = 2;
      end else if (m_mode[u] == 2 && rz) begin
        e_period[u] = 16'(n - m_trise[u]);
        e_high[u]   = 16'(m_tfall[u] - m_trise[u]);
        e_mstb[u]   = 1; e_valid[u] = 1;
        m_trise[u]  = n; m_mode[u] = 1;
      end else if (tmo) begin
        m_mode[u] = 0; e_stall[u] = 1; e_valid[u] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, n - 1);
    end
  endtask

  task automatic check_all();
    chk("s2.rise_stb",   r0,  e_rise[0]);
    chk("s2.fall_stb",   f0,  e_fall[0]);
    chk("s2.period",     p0,  e_period[0]);
    chk("s2.high_time",  h0,  e_high[0]);
    chk("s2.meas_stb",   ms0, e_mstb[0]);
    chk("s2.meas_valid", mv0, e_valid[0]);
    chk("s2.stall",      st0, e_stall[0]);
    chk("s3.rise_stb",   r1,  e_rise[1]);
    chk("s3.fall_stb",   f1,  e_fall[1]);
    chk("s3.period",     p1,  e_period[1]);
    chk("s3.high_time",  h1,  e_high[1]);
    chk("s3.meas_stb",   ms1, e_mstb[1]);
    chk("s3.meas_valid", mv1, e_valid[1]);
    chk("s3.stall",      st1, e_stall[1]);
  endtask

  task automatic cyc(input bit v, input bit c);
    @(negedge clk_ref);
    clk_in = v;
    clr    = c;
    @(posedge clk_ref);
    if (n >= MAXN) begin
      $display("FAIL cycle_budget: edge %0d exceeds limit %0d", n, MAXN);
      $fatal(1);
    end
    samp[n] = v;
    model_edge(c);
    n++;
    #1 check_all();
  endtask

  task automatic run_div(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) cyc(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) cyc(1'b0, 1'b0);
    end
  endtask

  // DIV=4 from a clean start: the first meas_stb must coincide with the 2nd rise_stb.
  task automatic first_meas(input string tag);
    int rises;
    bit got;
    rises = 0;
    got   = 0;
    for (int i = 0; i < 12; i++) begin
      cyc((i % 4) < 2, 1'b0);
      if (r0) rises++;
      if (ms0 && !got) begin
        got = 1;
        chk({tag, "_rise_count_at_meas"}, 16'(rises), 16'd2);
      end
    end
    chk({tag, "_meas_seen"}, {15'd0, got}, 16'd1);
    chk({tag, "_period"}, p0, 16'd4);
    chk({tag, "_high"},   h0, 16'd2);
  endtask

  initial begin
    int  t_saved;
    int  stall_edge;
    bit  will;
    bit  done;
    bit  exp6 [5];
    int  hi;
    int  lo;

    arst_n = 1'b0;
    clk_in = 1'b0;
    clr    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_ref);
    #1 check_all();
    chk("reset_period", p0, 16'd0);
    #2 arst_n = 1'b1;

    // DIV=4, 2 high / 2 low
    first_meas("t1");
    run_div(2, 2, 4);
    chk("t1_valid", {15'd0, mv0}, 16'd1);
    chk("t1_stall", {15'd0, st0}, 16'd0);

    // DIV=5 with both duty splits
    run_div(2, 3, 3);
    chk("t2a_period", p0, 16'd5);
    chk("t2a_high",   h0, 16'd2);
    run_div(3, 2, 3);
    chk("t2b_period", p0, 16'd5);
    chk("t2b_high",   h0, 16'd3);

    // Stall after TO cycles without a rise; period retained
    t_saved    = m_trise[0];
    stall_edge = -1;
    for (int i = 0; i < 200 && stall_edge < 0; i++) begin
      cyc(1'b0, 1'b0);
      if (st0) stall_edge = n - 1;
    end
    chk("t3_stall_latency", 16'(stall_edge - t_saved), 16'(TO));
    chk("t3_valid_cleared", {15'd0, mv0}, 16'd0);
    chk("t3_period_kept",   p0, 16'd5);
    chk("t3_high_kept",     h0, 16'd3);
    run_div(2, 2, 3);
    chk("t3_stall_sticky",  {15'd0, st0}, 16'd1);
    chk("t3_restart_valid", {15'd0, mv0}, 16'd1);
    chk("t3_restart_period", p0, 16'd4);
    cyc(1'b0, 1'b1);
    chk("t3_clr_stall",  {15'd0, st0}, 16'd0);
    chk("t3_clr_period", p0, 16'd0);

    // clr coincident with a rise registering in the low phase
    done = 0;
    for (int i = 0; i < 40; i++) begin
      will = !done && (m_mode[0] == 2) && smp(n - 2) && !smp(n - 3);
      cyc((i % 4) < 2, will);
      if (will) begin
        done = 1;
        chk("t4_meas_stb", {15'd0, ms0}, 16'd0);
        chk("t4_period",   p0, 16'd0);
        chk("t4_high",     h0, 16'd0);
        chk("t4_valid",    {15'd0, mv0}, 16'd0);
        chk("t4_rise_stb", {15'd0, r0}, 16'd1);
      end
    end
    chk("t4_clr_hit", {15'd0, done}, 16'd1);

    // Asynchronous reset while in the high phase
    run_div(2, 2, 3);
    #2 arst_n = 1'b0;
    clk_in = 1'b0;
    #1;
    chk("t5_period",   p0, 16'd0);
    chk("t5_high",     h0, 16'd0);
    chk("t5_valid",    {15'd0, mv0}, 16'd0);
    chk("t5_meas_stb", {15'd0, ms0}, 16'd0);
    chk("t5_rise_stb", {15'd0, r0}, 16'd0);
    chk("t5_fall_stb", {15'd0, f0}, 16'd0);
    chk("t5_stall",    {15'd0, st0}, 16'd0);
    model_reset();
    check_all();
    repeat (2) @(posedge clk_ref);
    #3 arst_n = 1'b1;
    first_meas("t5");

    // Single rise through the 3-stage synchroniser
    repeat (6) cyc(1'b0, 1'b0);
    exp6 = '{0, 0, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      chk($sformatf("t6_s3_rise_k%0d", i), {15'd0, r1}, {15'd0, exp6[i]});
    end
    repeat (4) cyc(1'b1, 1'b0);

    // Random duty/period with occasional stalls and clr pulses
    for (int it = 0; it < 250; it++) begin
      hi = $urandom_range(1, 8);
      lo = ($urandom_range(0, 19) == 0) ? $urandom_range(66, 90) : $urandom_range(1, 8);
      for (int i = 0; i < hi; i++) cyc(1'b1, $urandom_range(0, 39) == 0);
      for (int i = 0; i < lo; i++) cyc(1'b0, $urandom_range(0, 39) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
